// File: rtl/booth_product_accumulator_if.sv
// Valid/ready bundle between the Booth multiplier, the product accumulator and its consumer.
// master drives products and takes sums; slave is the accumulator itself.
interface booth_product_accumulator_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      product;
    logic [CNT_W-1:0] len;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             sat_flag;
    logic             busy;

    modport master (
        output in_valid, product, len, clear, out_ready,
        input  in_ready, out_valid, acc_out, sat_flag, busy
    );

    modport slave (
        input  in_valid, product, len, clear, out_ready,
        output in_ready, out_valid, acc_out, sat_flag, busy
    );
endinterface

// File: rtl/booth_product_accumulator.sv
// Saturating block accumulator for signed 16-bit Booth products.
// Sums len products per block and presents the sum over a valid/ready handshake.
module booth_product_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    booth_product_accumulator_if.slave   bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             sat_q, sat_d;

    logic             accept;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] count_inc;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum_wide;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_sat;

    // Handshake outputs depend on the state register only.
    assign bus.in_ready  = (state_q != StHold);
    assign bus.out_valid = (state_q == StHold);
    assign bus.busy      = (state_q != StIdle);
    assign bus.acc_out   = acc_q;
    assign bus.sat_flag  = sat_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign len_eff   = (bus.len == '0) ? CNT_W'(1) : bus.len;
    assign count_inc = count_q + CNT_W'(1);

    // One guard bit: a sign mismatch between the top two bits means overflow.
    assign prod_ext = {{(ACC_W-15){bus.product[15]}}, bus.product};
    assign sum_wide = {acc_q[ACC_W-1], acc_q} + prod_ext;
    assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum_sat  = !sum_ovf ? sum_wide[ACC_W-1:0] : (sum_wide[ACC_W] ? AccMin : AccMax);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        sat_d   = sat_q;
        if (bus.clear) begin
            state_d = StIdle;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        acc_d   = prod_ext[ACC_W-1:0];
                        count_d = CNT_W'(1);
                        len_d   = len_eff;
                        sat_d   = 1'b0;
                        state_d = (len_eff == CNT_W'(1)) ? StHold : StAccum;
                    end
                end
                StAccum: begin
                    if (accept) begin
                        acc_d   = sum_sat;
                        count_d = count_inc;
                        sat_d   = sat_q | sum_ovf;
                        if (count_inc == len_q) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= CNT_W'(1);
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Sequential accumulator that sits directly downstream of the combinational 8x8 signed Booth multiplier. It accepts a stream of signed 16-bit products over a valid/ready handshake and sums a programmable number of them into a saturating signed accumulator. It then presents the block sum on an output handshake. It is the MAC back-end for dot-product style use of the multiplier.

## Interface
- ACC_W, 24, accumulator and result width in bits; must be at least 17.
- CNT_W, 8, width of the block-length field and the internal beat counter.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- product  input  16  signed product (multiplier output c[15:0]).
- len  input  CNT_W  products per block; sampled on the first beat of a block; 0 is treated as 1.
- clear  input  1  synchronous abort; highest priority after rst.
- out_valid  output  1  block sum available.
- out_ready  input  1  consumer takes the sum.
- acc_out  output  ACC_W  signed block sum.
- sat_flag  output  1  sticky per block; set if any addition in the block saturated.
- busy  output  1  high in ACCUM or HOLD.

## Operation
- States: IDLE, ACCUM, HOLD.
- A beat is accepted when in_valid and in_ready are both high on a rising edge.
- IDLE:
  - in_ready=1.
  - On accept: acc = sign-extended product; count=1; len_q = max(len,1); sat_flag=0.
  - Next state is HOLD if len_q==1, otherwise ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept: acc = sat(acc + sext(product)); count++.
  - When the incremented count equals len_q, go to HOLD.
  - No accept means no change to any state.
- HOLD:
  - in_ready=0; out_valid=1.
  - acc_out and sat_flag are held stable.
  - On out_ready=1, go to IDLE. acc is not cleared; it is overwritten by the next first beat.
- Arithmetic:
  - The sum is formed at ACC_W+1 bits.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to that value. If it is below -2^(ACC_W-1), clamp to that value.
  - Either clamp sets sat_flag. Once set, sat_flag stays set until the next block's first beat.
- clear:
  - Next state is IDLE; acc=0; count=0; sat_flag=0; out_valid drops.
  - Any beat presented in the same cycle is discarded. in_ready is still high in that cycle, so the producer sees an accept, but the beat is dropped.
- len changes after the first beat have no effect on the current block.
- The count never wraps: len_q is at most 2^CNT_W-1, and the transition to HOLD happens at equality.

## Timing
- Reset values: state=IDLE, acc=0, count=0, sat_flag=0, out_valid=0, in_ready=1, busy=0, acc_out=0.
- acc_out is driven directly from the acc register. It is valid when out_valid=1 and reflects the partial sum at other times.
- Latency: out_valid rises on the edge after the last beat is accepted, i.e. in the first cycle after that edge.
- Throughput:
  - One beat per cycle in IDLE and ACCUM.
  - At least one HOLD cycle between blocks, because in_ready=0 in HOLD.
  - With out_ready tied high, the steady state is len_q+1 cycles per block.
- in_ready and out_valid are functions of the state register only; there is no combinational path from in_valid or out_ready.
- rst deassertion mid-block: the block restarts in IDLE and the partial sum is lost.
- clear and out_ready both high in HOLD: clear wins. The result is zeroed and the consumer must not take the sum in that cycle.

## Test plan
- Reset then idle: assert rst for 3 cycles with random inputs. Expect out_valid=0, in_ready=1, acc_out=0, busy=0 throughout and after release.
- Basic block: len=4; products 100, -50, 16384, -1 on consecutive cycles; out_ready=1. Expect out_valid exactly one cycle after the 4th beat, acc_out=16433, sat_flag=0, and in_ready=1 again on the next cycle.
- len=0 and len=1: a single beat of -16384 with len=0. Expect HOLD after 1 beat with acc_out=-16384; the same result for len=1.
- Saturation (ACC_W=17): len=3; products 32767, 32767, 32767. Expect acc_out=65535 and sat_flag=1. A following block of len=1 with product 5 gives acc_out=5, sat_flag=0.
- Backpressure and gaps: len=3 with in_valid gaps between beats; hold out_ready=0 for 5 cycles. Expect acc_out stable, in_ready=0 in HOLD, and no beat accepted; release out_ready and check the next block starts clean.
- clear mid-block and in HOLD:
  - Pulse clear after 2 of 4 beats. Expect IDLE, acc_out=0, and the next 4 beats summed correctly.
  - Pulse clear together with out_ready in HOLD. Expect out_valid=0 on the next cycle and acc_out=0.
